// File: rtl/cpu_pkg.sv
// Shared types for the register-file write-back path: source ids and default widths.
package cpu_pkg;

    localparam int WB_BUS_WIDTH = 8;
    localparam int WB_DEPTH     = 8;
    localparam int WB_AW        = $clog2(WB_DEPTH);

    typedef enum logic {
        WB_ALU = 1'b0,
        WB_MEM = 1'b1
    } wb_src_e;

    typedef logic [WB_AW-1:0]        regaddr_t;
    typedef logic [WB_BUS_WIDTH-1:0] reg_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-request round-robin arbiter; on a tie the source that did not win last gets the grant.
module rr_arbiter2
    import cpu_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);

    wb_src_e last_grant;

    // Bit 0 is the ALU, bit 1 the load unit.
    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            grant = (last_grant == WB_ALU) ? 2'b10 : 2'b01;
        end
    end

    // Reset to MEM so the first tie after reset goes to the ALU.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= WB_MEM;
        end else if (advance && (grant != 2'b00)) begin
            last_grant <= grant[1] ? WB_MEM : WB_ALU;
        end
    end

endmodule

// File: rtl/regfile_writeback_arbiter.sv
// Register-file write port controller: arbitrates ALU and load results into one registered
// write stage and keeps the pending-write scoreboard used by decode for read stalls.
module regfile_writeback_arbiter
    import cpu_pkg::*;
#(
    parameter int BUS_WIDTH = WB_BUS_WIDTH,
    parameter int DEPTH     = WB_DEPTH,
    parameter int ZERO_REG  = 1,
    parameter int AW        = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 alu_valid,
    output logic                 alu_ready,
    input  logic [AW-1:0]        alu_rd,
    input  logic [BUS_WIDTH-1:0] alu_data,
    input  logic                 mem_valid,
    output logic                 mem_ready,
    input  logic [AW-1:0]        mem_rd,
    input  logic [BUS_WIDTH-1:0] mem_data,
    input  logic                 issue_valid,
    input  logic [AW-1:0]        issue_rd,
    input  logic                 hold,
    output logic                 we,
    output logic [AW-1:0]        wr_addr,
    output logic [BUS_WIDTH-1:0] wr_data,
    output logic [DEPTH-1:0]     busy
);

    logic [1:0]           req;
    logic [1:0]           grant;
    logic                 accept;
    logic [AW-1:0]        sel_rd;
    logic [BUS_WIDTH-1:0] sel_data;
    logic                 drop;
    logic [DEPTH-1:0]     busy_next;

    // Gating requests with rst_n keeps both readys low while reset is held.
    assign req = {mem_valid, alu_valid} & {2{~hold & rst_n}};

    rr_arbiter2 u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .advance (accept),
        .grant   (grant)
    );

    assign alu_ready = grant[0];
    assign mem_ready = grant[1];
    assign accept    = |grant;
    assign sel_rd    = grant[1] ? mem_rd   : alu_rd;
    assign sel_data  = grant[1] ? mem_data : alu_data;
    assign drop      = (ZERO_REG != 0) && (sel_rd == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we      <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else if (accept && !drop) begin
            we      <= 1'b1;
            wr_addr <= sel_rd;
            wr_data <= sel_data;
        end else begin
            we      <= 1'b0;
        end
    end

    // Clear first, then set, so a new reservation survives the retiring write.
    always_comb begin
        busy_next = busy;
        if (we) begin
            busy_next[wr_addr] = 1'b0;
        end
        if (issue_valid && !((ZERO_REG != 0) && (issue_rd == '0))) begin
            busy_next[issue_rd] = 1'b1;
        end
        if (ZERO_REG != 0) begin
            busy_next[0] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end

endmodule

// File: tb/tb_regfile_writeback_arbiter.sv
// Directed bench: stimulus pushes expected writes into a queue, a negedge monitor pops them.
module tb_regfile_writeback_arbiter;
    import cpu_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       alu_valid, mem_valid, issue_valid, hold;
    logic       alu_ready, mem_ready;
    regaddr_t   alu_rd, mem_rd, issue_rd, wr_addr;
    reg_t       alu_data, mem_data, wr_data;
    logic       we;
    logic [7:0] busy;

    typedef struct {
        int       cyc;
        regaddr_t addr;
        reg_t     data;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    regfile_writeback_arbiter #(.BUS_WIDTH(8), .DEPTH(8), .ZERO_REG(1)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .alu_valid   (alu_valid),
        .alu_ready   (alu_ready),
        .alu_rd      (alu_rd),
        .alu_data    (alu_data),
        .mem_valid   (mem_valid),
        .mem_ready   (mem_ready),
        .mem_rd      (mem_rd),
        .mem_data    (mem_data),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .hold        (hold),
        .we          (we),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Monitor: every write the DUT presents must match the head of the queue in the expected cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (we) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL write_unexpected: got addr %0h data %0h, none expected", wr_addr, wr_data);
                    end else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        if (e.cyc != cyc || wr_addr !== e.addr || wr_data !== e.data) begin
                            errors++;
                            $display("FAIL write: got cyc %0d addr %0h data %0h expected cyc %0d addr %0h data %0h",
                                     cyc, wr_addr, wr_data, e.cyc, e.addr, e.data);
                        end
                    end
                end else if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
                    exp_t e;
                    e = exp_q.pop_front();
                    checks++;
                    errors++;
                    $display("FAIL write_missing: got we 0 expected addr %0h data %0h", e.addr, e.data);
                end
            end
        end
    end

    task automatic idle_inputs();
        alu_valid = 0; alu_rd = '0; alu_data = '0;
        mem_valid = 0; mem_rd = '0; mem_data = '0;
        issue_valid = 0; issue_rd = '0; hold = 0;
    endtask

    // Called at posedge+1; drives one cycle, checks readys, queues expected writes.
    task automatic step(input logic av, input int ard, input int ad,
                        input logic mv, input int mrd, input int md,
                        input logic h, input logic iv, input int ird,
                        input logic exp_ar, input logic exp_mr);
        alu_valid = av; alu_rd = regaddr_t'(ard); alu_data = reg_t'(ad);
        mem_valid = mv; mem_rd = regaddr_t'(mrd); mem_data = reg_t'(md);
        hold = h; issue_valid = iv; issue_rd = regaddr_t'(ird);
        #3;
        chk("alu_ready", {31'd0, alu_ready}, {31'd0, exp_ar});
        chk("mem_ready", {31'd0, mem_ready}, {31'd0, exp_mr});
        if (exp_ar && ard != 0) exp_q.push_back('{cyc + 1, regaddr_t'(ard), reg_t'(ad)});
        if (exp_mr && mrd != 0) exp_q.push_back('{cyc + 1, regaddr_t'(mrd), reg_t'(md)});
        @(posedge clk);
        #1;
        idle_inputs();
    endtask

    task automatic nop();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        idle_inputs();
        rst_n = 0;
        alu_valid = 1; mem_valid = 1; alu_rd = 3'd2; mem_rd = 3'd3;
        #2;
        chk("rst_alu_ready", {31'd0, alu_ready}, 0);
        chk("rst_mem_ready", {31'd0, mem_ready}, 0);
        chk("rst_we", {31'd0, we}, 0);
        chk("rst_wr_addr", {29'd0, wr_addr}, 0);
        chk("rst_wr_data", {24'd0, wr_data}, 0);
        chk("rst_busy", {24'd0, busy}, 0);
        idle_inputs();
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        @(posedge clk); #1;

        // Reset mid-write
        step(0, 0, 0, 0, 0, 0, 0, 1, 3, 0, 0);
        chk("busy_issue3", {24'd0, busy}, 32'h08);
        step(1, 3, 8'h33, 0, 0, 0, 0, 0, 0, 1, 0);
        chk("we_before_rst", {31'd0, we}, 1);
        rst_n = 0;
        #1;
        chk("rst_mid_we", {31'd0, we}, 0);
        chk("rst_mid_busy", {24'd0, busy}, 0);
        exp_q.delete();
        @(posedge clk); #1;
        rst_n = 1;
        @(posedge clk); #1;

        // Tie round robin after reset: ALU, MEM, ALU, MEM
        step(1, 1, 8'h11, 1, 2, 8'h22, 0, 0, 0, 1, 0);
        step(1, 1, 8'h12, 1, 2, 8'h23, 0, 0, 0, 0, 1);
        step(1, 1, 8'h13, 1, 2, 8'h24, 0, 0, 0, 1, 0);
        step(1, 1, 8'h14, 1, 2, 8'h25, 0, 0, 0, 0, 1);

        // Hold freezes acceptance, then resumes with ALU
        step(1, 1, 8'h15, 1, 2, 8'h26, 1, 0, 0, 0, 0);
        step(1, 1, 8'h15, 1, 2, 8'h26, 0, 0, 0, 1, 0);

        // Single sources
        step(1, 5, 8'hA5, 0, 0, 0, 0, 0, 0, 1, 0);
        nop();
        nop();
        step(0, 0, 0, 1, 6, 8'h66, 0, 0, 0, 0, 1);
        nop();

        // Scoreboard set/clear
        step(0, 0, 0, 0, 0, 0, 0, 1, 4, 0, 0);
        chk("busy_set4", {24'd0, busy}, 32'h10);
        nop();
        chk("busy_hold4", {24'd0, busy}, 32'h10);
        step(1, 4, 8'h44, 0, 0, 0, 0, 0, 0, 1, 0);
        chk("busy_write_cycle4", {24'd0, busy}, 32'h10);
        nop();
        chk("busy_clear4", {24'd0, busy}, 32'h00);
        step(0, 0, 0, 0, 0, 0, 0, 1, 4, 0, 0);
        step(1, 4, 8'h45, 0, 0, 0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1, 4, 0, 0);
        chk("busy_set_wins", {24'd0, busy}, 32'h10);
        step(1, 4, 8'h46, 0, 0, 0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1, 7, 0, 0);
        chk("busy_independent", {24'd0, busy}, 32'h80);

        // Register zero is hardwired
        step(1, 0, 8'hFF, 0, 0, 0, 0, 0, 0, 1, 0);
        chk("zero_we", {31'd0, we}, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        chk("zero_busy", {24'd0, busy}, 32'h80);

        // Same rd from both sources: last grant was ALU, so MEM wins, ALU retries
        step(1, 3, 8'h31, 1, 3, 8'h32, 0, 0, 0, 0, 1);
        step(1, 3, 8'h31, 0, 0, 0, 0, 0, 0, 1, 0);
        nop();
        nop();

        chk("queue_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
